regfile_nwide_sb: RTL and testbench
===================================

Name: regfile_nwide_sb

Overview:
- Parametrised N-lane register file with an integrated busy-bit scoreboard for the superscalar LEGv8 core.
- Generalises the fixed dual-issue register file to LANES issue lanes, each with two read ports and one write port.
- Adds same-cycle write-to-read bypass, deterministic lane priority on colliding writes, a hardwired zero register (XZR), and per-register busy tracking used by issue logic to stall.

Parameters:
LANES, 2, number of issue lanes (1..4)
DATA_W, 64, register width
ADDR_W, 5, register index width (2**ADDR_W registers)
ZERO_REG, 31, index that reads 0, ignores writes, never busy

Ports:
CLOCK  in  1  rising-edge clock
RESET  in  1  asynchronous, active-low reset
rd_addr_a  in  LANES*ADDR_W  source register A per lane; lane i uses bits [i*ADDR_W +: ADDR_W]
rd_addr_b  in  LANES*ADDR_W  source register B per lane
rd_data_a  out  LANES*DATA_W  read data A per lane
rd_data_b  out  LANES*DATA_W  read data B per lane
busy_a  out  LANES  source A pending (no valid value yet)
busy_b  out  LANES  source B pending
wr_en  in  LANES  writeback enable per lane
wr_addr  in  LANES*ADDR_W  writeback destination per lane
wr_data  in  LANES*DATA_W  writeback data per lane
iss_en  in  LANES  issue strobe per lane; marks destination busy
iss_dst  in  LANES*ADDR_W  destination register of the issued instruction
busy_vec  out  2**ADDR_W  registered scoreboard state
wr_conflict  out  1  registered flag: two or more lanes wrote the same non-zero register last cycle

Behaviour:
- Reset (RESET=0, asynchronous): all registers cleared to 0, busy_vec=0, wr_conflict=0. Reads during reset return 0 except where bypass applies; bypass stays active during reset.
- Reads are combinational, with zero cycles of latency. Priority order:
  - (1) address==ZERO_REG gives 0.
  - (2) Otherwise, if any lane has wr_en=1 with wr_addr==address, return the wr_data of the highest-index matching lane.
  - (3) Otherwise, return the stored value.
- Writes take effect at the rising CLOCK edge.
  - If several lanes write the same register, the highest-index lane wins. This matches program order: a higher lane is younger.
  - Writes to ZERO_REG are dropped.
- wr_conflict is set at the edge for one cycle when two or more enabled lanes share a non-ZERO_REG wr_addr. Otherwise it is 0 at that edge.
- Scoreboard, per register r at each edge:
  - set = any iss_en lane with iss_dst==r.
  - clr = any wr_en lane with wr_addr==r.
  - busy_next = set | (busy & ~clr). Set wins over a simultaneous clear, because the new producer supersedes the old one.
  - r==ZERO_REG stays 0 always.
- busy_a[i] = busy_vec[rd_addr_a_i] & ~(any wr_en with wr_addr==rd_addr_a_i). A same-cycle writeback is already bypassed, so it is not reported busy. busy_b is defined the same way.
- An iss_en in the current cycle does not affect busy_a/busy_b until the next cycle. Issue logic handles intra-group dependencies itself.
- The scoreboard is single-bit with no tags. If a register is issued twice before writeback (WAW), the first writeback clears busy; issue logic must not issue WAW while busy.
- Lanes at indices >= LANES do not exist; no X propagation from unused bits.
- All outputs are fully defined for every input combination; no latches.

Test Plan:
- Reset: hold RESET=0, then release; read all 32 registers on lane 0 A/B -> every rd_data=0, busy_vec=0, wr_conflict=0.
- Write/bypass: wr_en=01, wr_addr0=5, wr_data0=0x1234 while rd_addr_a0=5 -> rd_data_a0=0x1234 in the same cycle. After the edge, with wr_en=0 -> still 0x1234.
- Lane priority: wr_en=11, both wr_addr=7, data 0xAAAA (lane0) and 0xBBBB (lane1) -> same-cycle read of X7 =0xBBBB; after the edge X7=0xBBBB and wr_conflict=1 for exactly one cycle.
- XZR: write 0xFFFF to 31 and issue to 31 -> reads of 31 return 0, busy_vec[31]=0, wr_conflict=0 even if both lanes target 31.
- Scoreboard: issue dst=9 -> next cycle busy_vec[9]=1 and busy_a=1 for reads of 9. Writeback X9=0x55 -> busy_a=0 and data=0x55 that cycle; busy_vec[9]=0 after the edge. Simultaneous issue and writeback of 9 -> busy_vec[9]=1 afterward.
- Reset mid-operation: with X3=0x77 and busy_vec[3]=1, assert RESET=0 asynchronously between edges -> X3=0 and busy_vec=0 immediately, without waiting for CLOCK.

Source files
------------

// File: rtl/regfile_nwide_sb_if.sv
// regfile_nwide_sb_if: read, writeback, issue and scoreboard signals of the N-lane register file
interface regfile_nwide_sb_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [LANES*ADDR_W-1:0] rd_addr_a;
  logic [LANES*ADDR_W-1:0] rd_addr_b;
  logic [LANES*DATA_W-1:0] rd_data_a;
  logic [LANES*DATA_W-1:0] rd_data_b;
  logic [LANES-1:0]        busy_a;
  logic [LANES-1:0]        busy_b;
  logic [LANES-1:0]        wr_en;
  logic [LANES*ADDR_W-1:0] wr_addr;
  logic [LANES*DATA_W-1:0] wr_data;
  logic [LANES-1:0]        iss_en;
  logic [LANES*ADDR_W-1:0] iss_dst;
  logic [2**ADDR_W-1:0]    busy_vec;
  logic                    wr_conflict;
  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_dst,
    input  rd_data_a, rd_data_b, busy_a, busy_b, busy_vec, wr_conflict
  );
  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, iss_en, iss_dst,
    output rd_data_a, rd_data_b, busy_a, busy_b, busy_vec, wr_conflict
  );
endinterface

// File: rtl/regfile_nwide_sb.sv
// regfile_nwide_sb: N-lane register file with write bypass, lane-priority writes, XZR and busy scoreboard
module regfile_nwide_sb #(
  parameter int LANES    = 2,
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input logic CLOCK,
  input logic RESET,
  regfile_nwide_sb_if.slave bus
);
  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0] busy_q, busy_nxt, set, clr;
  logic conflict, conflict_q;
  logic [LANES-1:0] wr_en, iss_en, ba, bb;
  logic [LANES*ADDR_W-1:0] wr_addr, iss_dst, ra, rb;
  logic [LANES*DATA_W-1:0] wr_data, da, db;
  assign wr_en   = bus.wr_en;
  assign wr_addr = bus.wr_addr;
  assign wr_data = bus.wr_data;
  assign iss_en  = bus.iss_en;
  assign iss_dst = bus.iss_dst;
  assign ra      = bus.rd_addr_a;
  assign rb      = bus.rd_addr_b;
  // {busy, data} for one source; later lanes overwrite earlier hits so the youngest writer wins
  function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a);
    logic hit;
    logic [DATA_W-1:0] d;
    hit = 1'b0;
    d = regs[a];
    for (int i = 0; i < LANES; i++)
      if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == a) begin
        hit = 1'b1;
        d = wr_data[i*DATA_W +: DATA_W];
      end
    return a == ZR ? '0 : {busy_q[a] & ~hit, d};
  endfunction
  always_comb begin
    ba = '0;
    bb = '0;
    da = '0;
    db = '0;
    for (int i = 0; i < LANES; i++) begin
      {ba[i], da[i*DATA_W +: DATA_W]} = lookup(ra[i*ADDR_W +: ADDR_W]);
      {bb[i], db[i*DATA_W +: DATA_W]} = lookup(rb[i*ADDR_W +: ADDR_W]);
    end
  end
  always_comb begin
    set = '0;
    clr = '0;
    conflict = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (iss_en[i]) set[iss_dst[i*ADDR_W +: ADDR_W]] = 1'b1;
      if (wr_en[i]) clr[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
      for (int j = 0; j < i; j++)
        if (wr_en[i] && wr_en[j] && wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W]
            && wr_addr[i*ADDR_W +: ADDR_W] != ZR)
          conflict = 1'b1;
    end
    set[ZR] = 1'b0;
    busy_nxt = set | (busy_q & ~clr);
  end
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy_q <= '0;
      conflict_q <= 1'b0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] != ZR)
          regs[wr_addr[i*ADDR_W +: ADDR_W]] <= wr_data[i*DATA_W +: DATA_W];
      busy_q <= busy_nxt;
      conflict_q <= conflict;
    end
  assign bus.rd_data_a   = da;
  assign bus.rd_data_b   = db;
  assign bus.busy_a      = ba;
  assign bus.busy_b      = bb;
  assign bus.busy_vec    = busy_q;
  assign bus.wr_conflict = conflict_q;
endmodule

// File: tb/tb_regfile_nwide_sb.sv
// tb_regfile_nwide_sb: directed checks of bypass, lane priority, XZR, scoreboard and async reset
module tb_regfile_nwide_sb;
  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  regfile_nwide_sb_if #(.LANES(2), .DATA_W(64), .ADDR_W(5)) bus ();
  regfile_nwide_sb #(.LANES(2), .DATA_W(64), .ADDR_W(5), .ZERO_REG(31)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus(bus.slave)
  );
  always #5 CLOCK = ~CLOCK;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask
  task automatic idle;
    bus.wr_en = '0;
    bus.iss_en = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.iss_dst = '0;
  endtask
  initial begin
    idle();
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    #12;
    RESET = 1'b1;
    #1;
    for (int r = 0; r < 32; r++) begin
      bus.rd_addr_a[4:0] = 5'(r);
      bus.rd_addr_b[4:0] = 5'(r);
      #1;
      check("reset_rd_a", bus.rd_data_a[63:0], 64'h0);
      check("reset_rd_b", bus.rd_data_b[63:0], 64'h0);
    end
    check("reset_busy_vec", 64'(bus.busy_vec), 64'h0);
    check("reset_conflict", 64'(bus.wr_conflict), 64'h0);
    tick();
    bus.wr_en = 2'b01;
    bus.wr_addr[4:0] = 5'd5;
    bus.wr_data[63:0] = 64'h1234;
    bus.rd_addr_a[4:0] = 5'd5;
    #1;
    check("bypass_x5", bus.rd_data_a[63:0], 64'h1234);
    check("bypass_busy", 64'(bus.busy_a[0]), 64'h0);
    tick();
    idle();
    #1;
    check("stored_x5", bus.rd_data_a[63:0], 64'h1234);
    check("diff_addr_conflict", 64'(bus.wr_conflict), 64'h0);
    bus.wr_en = 2'b11;
    bus.wr_addr = {5'd7, 5'd7};
    bus.wr_data = {64'hBBBB, 64'hAAAA};
    bus.rd_addr_a = {5'd7, 5'd7};
    #1;
    check("prio_bypass_l0", bus.rd_data_a[63:0], 64'hBBBB);
    check("prio_bypass_l1", bus.rd_data_a[127:64], 64'hBBBB);
    tick();
    idle();
    #1;
    check("prio_stored", bus.rd_data_a[63:0], 64'hBBBB);
    check("conflict_set", 64'(bus.wr_conflict), 64'h1);
    tick();
    check("conflict_clear", 64'(bus.wr_conflict), 64'h0);
    bus.wr_en = 2'b11;
    bus.wr_addr = {5'd11, 5'd10};
    bus.wr_data = {64'h11, 64'h10};
    tick();
    idle();
    #1;
    check("distinct_no_conflict", 64'(bus.wr_conflict), 64'h0);
    bus.rd_addr_a = {5'd11, 5'd10};
    #1;
    check("x10", bus.rd_data_a[63:0], 64'h10);
    check("x11", bus.rd_data_a[127:64], 64'h11);
    bus.wr_en = 2'b11;
    bus.wr_addr = {5'd31, 5'd31};
    bus.wr_data = {64'hFFFF, 64'hFFFF};
    bus.iss_en = 2'b01;
    bus.iss_dst[4:0] = 5'd31;
    bus.rd_addr_a[4:0] = 5'd31;
    #1;
    check("xzr_bypass", bus.rd_data_a[63:0], 64'h0);
    tick();
    idle();
    #1;
    check("xzr_stored", bus.rd_data_a[63:0], 64'h0);
    check("xzr_busy", 64'(bus.busy_vec[31]), 64'h0);
    check("xzr_conflict", 64'(bus.wr_conflict), 64'h0);
    bus.iss_en = 2'b01;
    bus.iss_dst[4:0] = 5'd9;
    tick();
    idle();
    bus.rd_addr_a[4:0] = 5'd9;
    bus.rd_addr_b[9:5] = 5'd9;
    #1;
    check("sb_busy_vec_set", 64'(bus.busy_vec), 64'h200);
    check("sb_busy_a", 64'(bus.busy_a[0]), 64'h1);
    check("sb_busy_b_l1", 64'(bus.busy_b[1]), 64'h1);
    bus.wr_en = 2'b10;
    bus.wr_addr[9:5] = 5'd9;
    bus.wr_data[127:64] = 64'h55;
    #1;
    check("sb_wb_busy_a", 64'(bus.busy_a[0]), 64'h0);
    check("sb_wb_data", bus.rd_data_a[63:0], 64'h55);
    tick();
    idle();
    #1;
    check("sb_cleared", 64'(bus.busy_vec[9]), 64'h0);
    check("sb_x9", bus.rd_data_b[127:64], 64'h55);
    bus.iss_en = 2'b01;
    bus.iss_dst[4:0] = 5'd9;
    bus.wr_en = 2'b10;
    bus.wr_addr[9:5] = 5'd9;
    bus.wr_data[127:64] = 64'h66;
    tick();
    idle();
    #1;
    check("sb_set_wins", 64'(bus.busy_vec[9]), 64'h1);
    check("sb_set_wins_data", bus.rd_data_a[63:0], 64'h66);
    bus.wr_en = 2'b01;
    bus.wr_addr[4:0] = 5'd3;
    bus.wr_data[63:0] = 64'h77;
    bus.iss_en = 2'b10;
    bus.iss_dst[9:5] = 5'd3;
    tick();
    idle();
    bus.rd_addr_a[4:0] = 5'd3;
    #1;
    check("pre_reset_x3", bus.rd_data_a[63:0], 64'h77);
    check("pre_reset_busy", 64'(bus.busy_vec), 64'h208);
    #1;
    RESET = 1'b0;
    #1;
    check("async_reset_x3", bus.rd_data_a[63:0], 64'h0);
    check("async_reset_busy", 64'(bus.busy_vec), 64'h0);
    #10;
    RESET = 1'b1;
    tick();
    check("post_reset_x3", bus.rd_data_a[63:0], 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
